// File: rtl/uart_time_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_time_pkg                                                 |
// | Purpose  : Shared types and constants for the UART time receiver: RX FSM |
// |            state encoding, ASCII digit bounds, characters per time frame |
// |            and a digit-classification helper.                           |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_time_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam int         FRAME_CHARS = 4;

  // True when the byte is an ASCII decimal character '0'..'9'.
  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_core                                                  |
// | Purpose  : 8N1 UART deserialiser. Synchronises rxd, validates the start  |
// |            bit at mid-bit, shifts 8 data bits LSB-first and checks the   |
// |            stop bit.                                                     |
// | Ports    : clk, rst_n (async, active-low), rxd (async serial in),        |
// |            byte_data[7:0] (last good byte), byte_valid (1-cycle pulse),  |
// |            frame_err (1-cycle pulse, stop bit low)                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_core
  import uart_time_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Two-flop synchroniser; both stages reset to the idle line level.
  logic rxd_meta_q;
  logic rxd_s_q;

  rx_state_t        state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [2:0]       bit_idx_q,    bit_idx_d;
  logic [7:0]       shift_q,      shift_d;
  logic [7:0]       byte_data_q,  byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q,  frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        // Re-check the line at mid start bit so short low glitches are dropped.
        if (cnt_q == HALF_CNT) begin
          if (!rxd_s_q) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        // Counter was zeroed at mid start bit, so each full period lands mid-bit.
        if (cnt_q == LAST_CNT) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          if (rxd_s_q) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/uart_time_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_time_rx                                                  |
// | Purpose  : UART receive path for the clock display. Receives four ASCII  |
// |            decimal characters (hour tens/units, minute tens/units) and   |
// |            presents them as BCD digits; partial frames are dropped on a  |
// |            bad character, a framing error or an inter-character gap.     |
// | Ports    : clk, rst_n (async, active-low), rxd (async serial in),        |
// |            byte_data[7:0], byte_valid, frame_err, char_err,              |
// |            digit_0..digit_3[3:0], time_valid                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_time_rx
  import uart_time_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int GAP_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       char_err,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic       time_valid
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [1:0]       LAST_IDX = 2'(FRAME_CHARS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  logic [1:0]       idx_q,        idx_d;
  logic [GAP_W-1:0] gap_q,        gap_d;
  logic [3:0]       stage_q [FRAME_CHARS];
  logic [3:0]       stage_d [FRAME_CHARS];
  logic [3:0]       digit_q [FRAME_CHARS];
  logic [3:0]       digit_d [FRAME_CHARS];
  logic             char_err_q,   char_err_d;
  logic             time_valid_q, time_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      gap_q        <= '0;
      char_err_q   <= 1'b0;
      time_valid_q <= 1'b0;
      for (int i = 0; i < FRAME_CHARS; i++) begin
        stage_q[i] <= '0;
        digit_q[i] <= '0;
      end
    end else begin
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      char_err_q   <= char_err_d;
      time_valid_q <= time_valid_d;
      for (int i = 0; i < FRAME_CHARS; i++) begin
        stage_q[i] <= stage_d[i];
        digit_q[i] <= digit_d[i];
      end
    end
  end

  always_comb begin
    idx_d        = idx_q;
    gap_d        = gap_q;
    char_err_d   = 1'b0;
    time_valid_d = 1'b0;
    for (int i = 0; i < FRAME_CHARS; i++) begin
      stage_d[i] = stage_q[i];
      digit_d[i] = digit_q[i];
    end

    if (rx_valid) begin
      // A byte arriving on the timeout cycle is still taken at the current index.
      gap_d = '0;
      if (is_ascii_digit(rx_byte)) begin
        stage_d[idx_q] = rx_byte[3:0];
        if (idx_q == LAST_IDX) begin
          for (int i = 0; i < FRAME_CHARS; i++) begin
            digit_d[i] = stage_d[i];
          end
          time_valid_d = 1'b1;
          idx_d        = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end else begin
        char_err_d = 1'b1;
        idx_d      = '0;
      end
    end else if (rx_ferr) begin
      idx_d = '0;
      gap_d = '0;
    end else if (idx_q != 2'd0) begin
      // Mid-frame: a stalled sender silently discards the partial frame.
      if (gap_q == GAP_MAX) begin
        idx_d = '0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  assign byte_data  = rx_byte;
  assign byte_valid = rx_valid;
  assign frame_err  = rx_ferr;
  assign char_err   = char_err_q;
  assign time_valid = time_valid_q;
  assign digit_0    = digit_q[0];
  assign digit_1    = digit_q[1];
  assign digit_2    = digit_q[2];
  assign digit_3    = digit_q[3];

endmodule
`default_nettype wire

// File: tb/tb_uart_time_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_time_rx                                               |
// | Purpose  : Self-checking bench for uart_time_rx. Character vectors come  |
// |            from a table; expected pulses are queued when a character is  |
// |            sent and compared by a monitor when the DUT pulses.           |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_time_rx;

  localparam int CPB = 16;
  localparam int GAP = 2000;

  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_CERR = 2;
  localparam int K_TV   = 3;

  localparam int P_NONE = 0;
  localparam int P_CERR = 1;
  localparam int P_TV   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid, frame_err, char_err, time_valid;
  logic [3:0] digit_0, digit_1, digit_2, digit_3;
  logic [15:0] digits;

  assign digits = {digit_0, digit_1, digit_2, digit_3};

  uart_time_rx #(
    .CLKS_PER_BIT (CPB),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .char_err   (char_err),
    .digit_0    (digit_0),
    .digit_1    (digit_1),
    .digit_2    (digit_2),
    .digit_3    (digit_3),
    .time_valid (time_valid)
  );

  always #5 clk = ~clk;

  // data: character sent; stop: stop-bit level; post: pulse expected one
  // cycle after byte_valid; val: byte_data expected on frame_err, otherwise
  // the digits expected on char_err / time_valid.
  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          post;
    logic [15:0] val;
  } vec_t;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  vec_t tbl[$];
  ev_t  evq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   last_bv = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_ev(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    evq.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [15:0] val);
    ev_t e;
    if (evq.size() == 0) begin
      chk("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = evq.pop_front();
      chk("pulse_kind", 32'(kind), 32'(e.kind));
      chk("pulse_value", {16'h0, val}, {16'h0, e.val});
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid) begin
      observe(K_BYTE, {8'h0, byte_data});
      last_bv = cyc;
    end
    if (frame_err)  observe(K_FERR, {8'h0, byte_data});
    if (char_err) begin
      observe(K_CERR, digits);
      chk("char_err_latency", 32'(cyc - last_bv), 32'd1);
    end
    if (time_valid) begin
      observe(K_TV, digits);
      chk("time_valid_latency", 32'(cyc - last_bv), 32'd1);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      wait_cycles(CPB);
    end
    rxd = stop;
    wait_cycles(CPB);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.stop) begin
      push_ev(K_BYTE, {8'h0, v.data});
      if (v.post == P_CERR) push_ev(K_CERR, v.val);
      if (v.post == P_TV)   push_ev(K_TV, v.val);
    end else begin
      push_ev(K_FERR, v.val);
    end
    send_byte(v.data, v.stop);
  endtask

  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) apply_vec(tbl[i]);
  endtask

  // Bounded wait for all expected pulses to have been seen.
  task automatic drain(input string name);
    int n = 0;
    while (evq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(evq.size()), 32'd0);
    evq.delete();
  endtask

  task automatic send_chars(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3,
                            input logic [15:0] exp_digits);
    apply_vec('{c0, 1'b1, P_NONE, 16'h0});
    apply_vec('{c1, 1'b1, P_NONE, 16'h0});
    apply_vec('{c2, 1'b1, P_NONE, 16'h0});
    apply_vec('{c3, 1'b1, P_TV,   exp_digits});
  endtask

  initial begin
    // 0..3: basic frame
    tbl.push_back('{8'h31, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h32, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h33, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h34, 1'b1, P_TV,   16'h1234});
    // 4..9: framing error on second char, then a fresh frame
    tbl.push_back('{8'h31, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h32, 1'b0, P_NONE, 16'h0031});
    tbl.push_back('{8'h35, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h39, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h30, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h30, 1'b1, P_TV,   16'h5900});
    // 10..15: bad character mid-frame, then a fresh frame
    tbl.push_back('{8'h31, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h41, 1'b1, P_CERR, 16'h5900});
    tbl.push_back('{8'h30, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h37, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h34, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h35, 1'b1, P_TV,   16'h0745});
    // 16..17: characters just outside '0'..'9'
    tbl.push_back('{8'h2F, 1'b1, P_CERR, 16'h0745});
    tbl.push_back('{8'h3A, 1'b1, P_CERR, 16'h0745});
    // 18..21: frame sent after a start-bit glitch
    tbl.push_back('{8'h30, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h30, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h30, 1'b1, P_NONE, 16'h0000});
    tbl.push_back('{8'h31, 1'b1, P_TV,   16'h0001});

    // Reset state
    #2;
    chk("reset_outputs",
        {8'h0, byte_valid, frame_err, char_err, time_valid, 4'h0, byte_data, digits[15:8]},
        32'h0);
    chk("reset_digits", {16'h0, digits}, 32'h0);
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(4);

    run_table(0, 3);
    drain("t1_frame");
    run_table(4, 9);
    drain("t2_frame_err");
    run_table(10, 17);
    drain("t4_char_err");
    chk("t4_digits_held", {16'h0, digits}, 32'h0000_0745);

    // Short low pulse on the line must not produce any byte
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    run_table(18, 21);
    drain("t3_glitch");

    // Inter-character gap longer than the timeout discards '1','2'
    apply_vec('{8'h31, 1'b1, P_NONE, 16'h0});
    apply_vec('{8'h32, 1'b1, P_NONE, 16'h0});
    wait_cycles(3000);
    send_chars(8'h33, 8'h34, 8'h35, 8'h36, 16'h3456);
    drain("t5_gap");
    chk("t5_digits", {16'h0, digits}, 32'h0000_3456);

    // Asynchronous reset during the data bits of the second character
    apply_vec('{8'h31, 1'b1, P_NONE, 16'h0});
    drain("t6_first_char");
    rxd = 1'b0;
    wait_cycles(CPB + 3 * CPB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_byte_data", {24'h0, byte_data}, 32'h0);
    chk("t6_reset_digits", {16'h0, digits}, 32'h0);
    chk("t6_reset_pulses", {28'h0, byte_valid, frame_err, char_err, time_valid}, 32'h0);
    rxd = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(3 * CPB);
    send_chars(8'h38, 8'h38, 8'h38, 8'h38, 16'h8888);
    drain("t6_after_reset");
    chk("t6_digits", {16'h0, digits}, 32'h0000_8888);

    wait_cycles(20);
    chk("final_queue_empty", 32'(evq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
